sprite_scanline_sequencer: RTL and testbench

Per-scanline controller for the sprite pipeline. On each line-start pulse from the video timing generator it:
- clears the back line buffer,
- runs the sprite evaluator, which fills the secondary array,
- runs `sprite_drawer`,
- swaps the double-buffered line buffers.

It owns the enable/done handshakes of both sub-blocks and the `line_number` they consume.

---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_seq_watchdog.sv | 38 +++
 rtl/sprite_scanline_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_sprite_scanline_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants and state encoding for the
// sprite scanline sequencer.
package sprite_pkg;

  localparam int DEF_DISPLAY_WIDTH  = 600;
  localparam int DEF_DISPLAY_HEIGHT = 480;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLEAR = 3'd1;
  localparam state_t ST_EVAL  = 3'd2;
  localparam state_t ST_DRAW  = 3'd3;
  localparam state_t ST_SWAP  = 3'd4;

  function automatic int line_w(input int width);
    return $clog2(width);
  endfunction

  localparam int DEF_LINE_NUMBER_WIDTH =
    line_w(DEF_DISPLAY_WIDTH);

endpackage

// File: rtl/sprite_seq_watchdog.sv
// sprite_seq_watchdog: per-phase cycle counter that flags a
// phase which has lasted CYCLES cycles without finishing.
module sprite_seq_watchdog #(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic active_i,
  output logic expired_o
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired_o = active_i &&
                     (cnt_q == CW'(CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (active_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sprite_scanline_sequencer.sv
// sprite_scanline_sequencer: clear / evaluate / draw / swap per line.
// Optional per-phase watchdog: define SPRITE_SEQ_WATCHDOG_EN.
module sprite_scanline_sequencer
  import sprite_pkg::*;
#(
  parameter int DISPLAY_WIDTH     = DEF_DISPLAY_WIDTH,
  parameter int DISPLAY_HEIGHT    = DEF_DISPLAY_HEIGHT,
  parameter int LINE_NUMBER_WIDTH = line_w(DISPLAY_WIDTH),
  parameter int WATCHDOG_CYCLES   = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic                         line_start,
  input  logic [LINE_NUMBER_WIDTH-1:0] next_line,
  output logic                         clear_we,
  output logic [$clog2(DISPLAY_WIDTH)-1:0] clear_addr,
  output logic                         eval_enable,
  input  logic                         eval_done,
  output logic                         draw_enable,
  input  logic                         draw_done,
  output logic [LINE_NUMBER_WIDTH-1:0] line_number,
  output logic                         buf_select,
  output logic                         line_done,
  output logic                         busy,
  output logic                         overrun,
  output logic                         timeout
);

  localparam int AW = $clog2(DISPLAY_WIDTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DISPLAY_WIDTH - 1);

  state_t state_q, state_d;

  logic          clear_we_q, clear_we_d;
  logic [AW-1:0] clear_addr_q, clear_addr_d;
  logic          eval_en_q, eval_en_d;
  logic          draw_en_q, draw_en_d;
  logic [LINE_NUMBER_WIDTH-1:0] line_num_q, line_num_d;
  logic          buf_sel_q, buf_sel_d;
  logic          line_done_q, line_done_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;

  logic line_ok;
  logic wd_expired;

  assign line_ok = line_start &&
                   (int'(next_line) < DISPLAY_HEIGHT);

`ifdef SPRITE_SEQ_WATCHDOG_EN
  logic wd_start;
  logic wd_active;

  assign wd_start =
    ((state_d == ST_EVAL) && (state_q != ST_EVAL)) ||
    ((state_d == ST_DRAW) && (state_q != ST_DRAW));
  assign wd_active = (state_q == ST_EVAL) ||
                     (state_q == ST_DRAW);

  sprite_seq_watchdog #(
    .CYCLES (WATCHDOG_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .start_i   (wd_start),
    .active_i  (wd_active),
    .expired_o (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    clear_we_d   = 1'b0;
    clear_addr_d = clear_addr_q;
    eval_en_d    = 1'b0;
    draw_en_d    = 1'b0;
    line_num_d   = line_num_q;
    buf_sel_d    = buf_sel_q;
    line_done_d  = 1'b0;
    overrun_d    = overrun_q;
    timeout_d    = timeout_q;

    if (frame_start) begin
      // Abort wins, but a same-cycle line request is still taken.
      state_d   = ST_IDLE;
      buf_sel_d = 1'b0;
      overrun_d = 1'b0;
      timeout_d = 1'b0;
      if (line_ok) begin
        state_d      = ST_CLEAR;
        clear_we_d   = 1'b1;
        clear_addr_d = '0;
        line_num_d   = next_line;
      end
    end else begin
      if (line_ok && (state_q != ST_IDLE)) begin
        overrun_d = 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (line_ok) begin
            state_d      = ST_CLEAR;
            clear_we_d   = 1'b1;
            clear_addr_d = '0;
            line_num_d   = next_line;
          end
        end
        ST_CLEAR: begin
          if (clear_addr_q == LAST_ADDR) begin
            state_d   = ST_EVAL;
            eval_en_d = 1'b1;
          end else begin
            clear_we_d   = 1'b1;
            clear_addr_d = clear_addr_q + AW'(1);
          end
        end
        ST_EVAL: begin
          if (eval_done) begin
            state_d   = ST_DRAW;
            draw_en_d = 1'b1;
          end else if (wd_expired) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
          end else begin
            eval_en_d = 1'b1;
          end
        end
        ST_DRAW: begin
          if (draw_done) begin
            state_d     = ST_SWAP;
            buf_sel_d   = ~buf_sel_q;
            line_done_d = 1'b1;
          end else if (wd_expired) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
          end else begin
            draw_en_d = 1'b1;
          end
        end
        ST_SWAP: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      clear_we_q   <= 1'b0;
      clear_addr_q <= '0;
      eval_en_q    <= 1'b0;
      draw_en_q    <= 1'b0;
      line_num_q   <= '0;
      buf_sel_q    <= 1'b0;
      line_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_we_q   <= clear_we_d;
      clear_addr_q <= clear_addr_d;
      eval_en_q    <= eval_en_d;
      draw_en_q    <= draw_en_d;
      line_num_q   <= line_num_d;
      buf_sel_q    <= buf_sel_d;
      line_done_q  <= line_done_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign clear_we    = clear_we_q;
  assign clear_addr  = clear_addr_q;
  assign eval_enable = eval_en_q;
  assign draw_enable = draw_en_q;
  assign line_number = line_num_q;
  assign buf_select  = buf_sel_q;
  assign line_done   = line_done_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_sprite_scanline_sequencer.sv
// tb_sprite_scanline_sequencer: directed and random stimulus
// against a timeline model of the line sequence.
module tb_sprite_scanline_sequencer;

  localparam int W  = 600;
  localparam int H  = 480;
  localparam int WD = 16;
`ifdef SPRITE_SEQ_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       line_start;
  logic [9:0] next_line;
  logic       clear_we;
  logic [9:0] clear_addr;
  logic       eval_enable;
  logic       eval_done;
  logic       draw_enable;
  logic       draw_done;
  logic [9:0] line_number;
  logic       buf_select;
  logic       line_done;
  logic       busy;
  logic       overrun;
  logic       timeout;

  always #5 clk = ~clk;

  sprite_scanline_sequencer #(
    .DISPLAY_WIDTH   (W),
    .DISPLAY_HEIGHT  (H),
    .WATCHDOG_CYCLES (WD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .line_start  (line_start),
    .next_line   (next_line),
    .clear_we    (clear_we),
    .clear_addr  (clear_addr),
    .eval_enable (eval_enable),
    .eval_done   (eval_done),
    .draw_enable (draw_enable),
    .draw_done   (draw_done),
    .line_number (line_number),
    .buf_select  (buf_select),
    .line_done   (line_done),
    .busy        (busy),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: one job with absolute cycle stamps for each phase.
  longint cyc = 0;
  longint t0  = 0;
  longint e_t = 0;
  longint d_t = 0;
  bit     job = 1'b0;
  bit     abt = 1'b0;
  bit     buf_e = 1'b0;
  bit     ovr_e = 1'b0;
  bit     to_e  = 1'b0;
  bit     bz_e  = 1'b0;
  logic [9:0] ln_e = '0;

  int nxt_de   = 0;
  int nxt_dd   = 0;
  bit nxt_hang = 1'b0;
  int n_clear  = 0;
  int n_ld     = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit ls, input logic [9:0] nl,
                      input bit fs, input bit rs);
    bit cw, ee, dr, ld, ed, dd, ok;
    @(posedge clk);
    #1;
    cyc++;
    if (job && cyc == d_t + 1) begin
      if (abt) to_e = 1'b1;
      else buf_e = ~buf_e;
    end
    cw   = job && cyc > t0 && cyc <= t0 + W;
    ee   = job && cyc > t0 + W && cyc <= e_t;
    dr   = job && cyc > e_t && cyc <= d_t;
    ld   = job && !abt && cyc == d_t + 1;
    bz_e = job && cyc > t0 &&
           cyc <= d_t + (abt ? 0 : 1);
    chk("clear_we", clear_we, cw);
    if (cw) chk("clear_addr", clear_addr, 32'(cyc - t0 - 1));
    chk("eval_enable", eval_enable, ee);
    chk("draw_enable", draw_enable, dr);
    chk("line_done", line_done, ld);
    chk("busy", busy, bz_e);
    chk("line_number", line_number, ln_e);
    chk("buf_select", buf_select, buf_e);
    chk("overrun", overrun, ovr_e);
    chk("timeout", timeout, to_e);
    if (clear_we === 1'b1) n_clear++;
    if (line_done === 1'b1) n_ld++;
    if (job && cyc > d_t) job = 1'b0;

    ed = job && cyc == e_t;
    if (!(job && cyc > t0 + W && cyc <= e_t))
      ed = ($urandom_range(0, 3) == 0);
    dd = job && !abt && cyc == d_t;
    if (!(job && cyc > e_t && cyc <= d_t))
      dd = ($urandom_range(0, 3) == 0);

    eval_done   = ed;
    draw_done   = dd;
    line_start  = ls;
    next_line   = nl;
    frame_start = fs;
    rst         = ~rs;

    if (rs) begin
      job = 1'b0; ln_e = '0; buf_e = 1'b0;
      ovr_e = 1'b0; to_e = 1'b0;
    end else begin
      if (fs) begin
        job = 1'b0; buf_e = 1'b0;
        ovr_e = 1'b0; to_e = 1'b0;
      end
      ok = ls && (nl < 10'(H));
      if (ok && (fs || !bz_e)) begin
        job  = 1'b1;
        t0   = cyc;
        ln_e = nl;
        e_t  = cyc + W + 1 + nxt_de;
        abt  = nxt_hang && WD_ON;
        if (!nxt_hang) d_t = e_t + 1 + nxt_dd;
        else if (WD_ON) d_t = e_t + WD;
        else d_t = e_t + 1000000;
      end else if (ok) begin
        ovr_e = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b0; line_start = 1'b0; frame_start = 1'b0;
    next_line = '0; eval_done = 1'b0; draw_done = 1'b0;

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_buf", buf_select, 0);

    // Normal line 5.
    nxt_de = 3; nxt_dd = 10;
    n_clear = 0; n_ld = 0;
    step(1, 10'd5, 0, 0);
    repeat (W + 30) step(0, 0, 0, 0);
    chk("norm_nclear", n_clear, W);
    chk("norm_nld", n_ld, 1);
    chk("norm_buf", buf_select, 1);
    chk("norm_line", line_number, 5);

    // Out-of-range line, then overrun during DRAW.
    step(1, 10'd480, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    chk("ign_busy", busy, 0);
    chk("ign_ovr", overrun, 0);
    nxt_dd = 20; n_ld = 0;
    step(1, 10'd7, 0, 0);
    repeat (W + 5) step(0, 0, 0, 0);
    chk("ovr_in_draw", draw_enable, 1);
    step(1, 10'd9, 0, 0);
    step(0, 0, 0, 0);
    chk("ovr_flag", overrun, 1);
    repeat (40) step(0, 0, 0, 0);
    chk("ovr_nld", n_ld, 1);
    chk("ovr_line", line_number, 7);

    // Frame abort mid-DRAW with buf_select=1.
    nxt_dd = 5;
    step(1, 10'd11, 0, 0);
    repeat (W + 30) step(0, 0, 0, 0);
    chk("pre_abort_buf", buf_select, 1);
    nxt_dd = 30;
    step(1, 10'd12, 0, 0);
    repeat (W + 8) step(0, 0, 0, 0);
    n_ld = 0;
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_draw", draw_enable, 0);
    chk("abort_buf", buf_select, 0);
    chk("abort_ovr", overrun, 0);
    repeat (40) step(0, 0, 0, 0);
    chk("abort_nld", n_ld, 0);

    // frame_start and line_start together, mid-CLEAR.
    nxt_dd = 2;
    step(1, 10'd20, 0, 0);
    repeat (10) step(0, 0, 0, 0);
    step(1, 10'd0, 1, 0);
    step(0, 0, 0, 0);
    chk("simul_busy", busy, 1);
    chk("simul_we", clear_we, 1);
    chk("simul_addr", clear_addr, 0);
    chk("simul_line", line_number, 0);
    repeat (W + 20) step(0, 0, 0, 0);

    // Reset mid-sequence.
    step(1, 10'd33, 0, 0);
    repeat (50) step(0, 0, 0, 0);
    n_ld = 0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_we", clear_we, 0);
    chk("mrst_line", line_number, 0);
    chk("mrst_buf", buf_select, 0);
    repeat (W + 20) step(0, 0, 0, 0);
    chk("mrst_nld", n_ld, 0);

    // Stuck draw_done.
    nxt_hang = 1'b1; nxt_de = 2;
    step(1, 10'd40, 0, 0);
    repeat (W + 23) step(0, 0, 0, 0);
`ifdef SPRITE_SEQ_WATCHDOG_EN
    chk("wd_timeout", timeout, 1);
    chk("wd_busy", busy, 0);
    chk("wd_buf", buf_select, 0);
`else
    chk("hang_draw", draw_enable, 1);
    chk("hang_busy", busy, 1);
`endif
    nxt_hang = 1'b0;
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("rec_busy", busy, 0);
    chk("rec_timeout", timeout, 0);

    for (int i = 0; i < 20000; i++) begin
      bit r_ls, r_fs, r_rs;
      nxt_de = $urandom_range(0, 12);
      nxt_dd = $urandom_range(0, 12);
      r_ls = bz_e ? ($urandom_range(0, 499) == 0)
                  : ($urandom_range(0, 19) == 0);
      r_fs = ($urandom_range(0, 2999) == 0);
      r_rs = ($urandom_range(0, 7999) == 0);
      step(r_ls, 10'($urandom_range(0, 1023)), r_fs, r_rs);
    end
    repeat (700) step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
